// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a byte stream (count hi/lo, then big-endian words) over valid/ready.
// It writes the words sequentially from BASE and keeps the core held until the image is in.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing 16-bit
// checksum, which is the mod-2^16 sum of all written words.
module imem_loader #(
    parameter int unsigned DEPTH = 256,
    parameter logic [15:0] BASE  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_W_HI,
        S_W_LO,
        S_LAST,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CK_HI,
        S_CK_LO,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // One bit wider than the count so that DEPTH = 65536 still compares correctly.
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;          // holds count-hi, word-hi or checksum-hi byte
    logic [15:0] remain_q, remain_d;  // words still to receive
    logic [15:0] addr_q, addr_d;      // next write address
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
`endif

    logic        accept;
    logic [15:0] word;

    // Handshake and status outputs are pure decodes of the current state.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_CNT_HI, S_CNT_LO, S_W_HI, S_W_LO: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CK_HI, S_CK_LO:                   in_ready = 1'b1;
`endif
            default:                            in_ready = 1'b0;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign word     = {hi_q, in_byte};
    assign cpu_hold = (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERR);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    // Next-state logic: byte assembly, write generation and load sequencing.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        remain_d  = remain_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_CNT_HI;
                    addr_d  = BASE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = 16'h0000;
`endif
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    hi_d    = in_byte;
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    remain_d = word;
                    if ({1'b0, word} > DEPTH_LIM) begin
                        state_d = S_ERR;
                    end else if (word == 16'h0000) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CK_HI;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_W_HI;
                    end
                end
            end
            S_W_HI: begin
                if (accept) begin
                    hi_d    = in_byte;
                    state_d = S_W_LO;
                end
            end
            S_W_LO: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = word;
                    addr_d    = addr_q + 16'd1;
                    remain_d  = remain_q - 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + word;
`endif
                    if (remain_q == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CK_HI;
`else
                        state_d = S_LAST;
`endif
                    end else begin
                        state_d = S_W_HI;
                    end
                end
            end
            // Lets the final write strobe go out before done is raised.
            S_LAST: state_d = S_DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CK_HI: begin
                if (accept) begin
                    hi_d    = in_byte;
                    state_d = S_CK_LO;
                end
            end
            S_CK_LO: begin
                if (accept) begin
                    state_d = (word == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hi_q      <= 8'h00;
            remain_q  <= 16'h0000;
            addr_q    <= 16'h0000;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 16'h0000;
            wr_data_q <= 16'h0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= 16'h0000;
`endif
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            remain_q  <= remain_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed loads checked against a behavioural
// model of the byte stream (expected writes, final status, completion cycle).
module tb_imem_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, wr_en, cpu_hold, done, error;
    logic [15:0] wr_addr, wr_data;

    imem_loader #(.DEPTH(DEPTH), .BASE(16'h0000)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int end_cyc = -1;
    int acc_cyc = 0;
    logic [15:0] got_addr[$];
    logic [15:0] got_data[$];
    logic [15:0] stim_words[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe and the first cycle done/error is seen.
    always @(negedge clk) begin
        if (wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
        if ((done || error) && end_cyc < 0) end_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at a negedge; returns once the byte has transferred.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        bit rdy;
        int n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            start    = poke && (g == 0);
            chk("stall_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        n = 0;
        rdy = 1'b0;
        do begin
            rdy = in_ready;
            @(negedge clk);
            n++;
        end while (!rdy && n < 50);
        acc_cyc = cyc;
        if (!rdy) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_load(input string name, input logic [15:0] cnt, input int maxgap,
                            input int stall_idx, input logic [15:0] ck_delta);
        logic [15:0] sum;
        logic [15:0] w;
        bit exp_err;
        int nw, exp_end;
        sum = 16'h0000;
        nw  = (cnt > DEPTH) ? 0 : int'(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got_addr.delete();
        got_data.delete();
        end_cyc = -1;
        chk({name, "_hold_at_start"}, 32'(cpu_hold), 32'd1);
        chk({name, "_done_clr"}, 32'(done), 32'd0);
        send_byte(cnt[15:8], int'($urandom_range(maxgap, 0)), 1'b0);
        send_byte(cnt[7:0], int'($urandom_range(maxgap, 0)), 1'b0);
        for (int i = 0; i < nw; i++) begin
            w = stim_words[i];
            sum = sum + w;
            send_byte(w[15:8], int'($urandom_range(maxgap, 0)), 1'b0);
            send_byte(w[7:0], (i == stall_idx) ? 5 : int'($urandom_range(maxgap, 0)), i == stall_idx);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (cnt <= DEPTH) begin
            w = sum + ck_delta;
            send_byte(w[15:8], int'($urandom_range(maxgap, 0)), 1'b0);
            send_byte(w[7:0], int'($urandom_range(maxgap, 0)), 1'b0);
        end
        exp_err = (cnt > DEPTH) || (ck_delta != 16'h0000);
        exp_end = acc_cyc;
`else
        exp_err = (cnt > DEPTH) || (ck_delta != ck_delta);
        exp_end = (nw == 0) ? acc_cyc : acc_cyc + 1;
`endif
        in_valid = 1'b0;
        for (int k = 0; k < 20 && end_cyc < 0; k++) @(negedge clk);
        @(negedge clk);
        chk({name, "_finished"}, 32'(end_cyc >= 0), 32'd1);
        chk({name, "_end_cycle"}, 32'(end_cyc), 32'(exp_end));
        chk({name, "_done"}, 32'(done), 32'(!exp_err));
        chk({name, "_error"}, 32'(error), 32'(exp_err));
        chk({name, "_cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
        chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({name, "_nwrites"}, 32'(got_addr.size()), 32'(nw));
        for (int i = 0; i < nw && i < got_addr.size(); i++) begin
            chk({name, "_addr"}, 32'(got_addr[i]), 32'(i));
            chk({name, "_data"}, 32'(got_data[i]), 32'(stim_words[i]));
        end
        $display("load %s: count=%0h writes=%0d done=%0b error=%0b", name, cnt,
                 got_addr.size(), done, error);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        $display("reset: cpu_hold=%0b done=%0b", cpu_hold, done);
        rst = 1'b0;
        @(negedge clk);

        stim_words = '{16'hA001, 16'hB002, 16'hC003};
        run_load("basic", 16'd3, 0, -1, 16'h0);
        run_load("stall", 16'd3, 0, 1, 16'h0);
        run_load("over", 16'h0101, 0, -1, 16'h0);
        run_load("zero", 16'h0000, 0, -1, 16'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        run_load("zero_badck", 16'h0000, 0, -1, 16'h1);
`endif

        // Reset after the first word has been written.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        in_valid = 1'b0;
        chk("midrst_wr_en_before", 32'(wr_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        $display("mid-load reset: wr_en=%0b cpu_hold=%0b", wr_en, cpu_hold);
        run_load("after_rst", 16'd3, 1, -1, 16'h0);

        stim_words = '{16'h8000, 16'h8001};
        run_load("ck_good", 16'd2, 0, -1, 16'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        run_load("ck_bad", 16'd2, 0, -1, 16'h1);
`endif

        for (int t = 0; t < 6; t++) begin
            stim_words.delete();
            for (int i = 0; i < 8; i++) stim_words.push_back(16'($urandom));
            run_load("rand", 16'($urandom_range(8, 1)), 2, int'($urandom_range(9, 0)), 16'h0);
        end
        run_load("rand_over", 16'(DEPTH + 1 + int'($urandom_range(100, 0))), 1, -1, 16'h0);
        stim_words.delete();
        for (int i = 0; i < DEPTH; i++) stim_words.push_back(16'($urandom));
        run_load("full", 16'(DEPTH), 0, -1, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
